palette_expander: RTL

Multi-depth indexed-colour pixel expander for the tiled video pipeline. Accepts 128-bit SDRAM words through a FIFO-style push interface and unpacks them into 1, 2, 4 or 8 bpp indices. Each index goes through a 256-entry palette RAM (optional base offset) and is pushed as a 24-bit RGB pixel into the DVI output FIFO. Parametrised successor of the 8bpp-only palette stage: selectable depth, palette banking via base offset, flush on ScreenStop. Sits between the mode/tile fetch logic and the DVI FIFO, in the MemClk domain.

---
 rtl/palette_expander_if.sv | 32 +++
 rtl/palette_expander.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/palette_expander_if.sv
// Word-in / pixel-out FIFO-style handshake bundle for the palette expander.
interface palette_expander_if #(
  parameter int unsigned WORD_W  = 128,
  parameter int unsigned COLOR_W = 24
);
  logic [WORD_W-1:0]  WORD_data;
  logic               WORD_wrreq;
  logic               WORD_wrfull;
  logic [COLOR_W-1:0] FF_data;
  logic               FF_wrreq;
  logic               FF_wrfull;

  // Expander side: consumes words, pushes pixels.
  modport slave (
    input  WORD_data,
    input  WORD_wrreq,
    output WORD_wrfull,
    output FF_data,
    output FF_wrreq,
    input  FF_wrfull
  );

  // Environment side: fetch logic pushing words, DVI FIFO taking pixels.
  modport master (
    output WORD_data,
    output WORD_wrreq,
    input  WORD_wrfull,
    input  FF_data,
    input  FF_wrreq,
    output FF_wrfull
  );
endinterface

// File: rtl/palette_expander.sv
// Indexed-colour expander: unpacks 1/2/4/8 bpp indices from a wide word,
// looks them up in a palette RAM and pushes RGB pixels to the DVI FIFO.
// Pipeline: S0 index extract -> S1 palette read -> S2 output register.
module palette_expander #(
  parameter int unsigned WORD_W  = 128,
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned COLOR_W = 24
) (
  input  logic               MemClk,
  input  logic               Reset,
  input  logic               ScreenStop,
  input  logic [1:0]         Mode,
  input  logic [IDX_W-1:0]   PalBase,
  palette_expander_if.slave  bus,
  input  logic [IDX_W-1:0]   PAL_wraddress,
  input  logic [COLOR_W-1:0] PAL_data,
  input  logic               PAL_wren
);

  localparam int unsigned RAW_W     = 8;
  localparam int unsigned CNT_W     = $clog2(WORD_W + 1);
  localparam int unsigned PAL_DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               wrfull_q;
  logic               word_wrfull;
  logic               word_accept;
  logic               load;
  logic               s0_adv;
  logic               adv;

  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  word_shift;
  logic [1:0]         mode_q;
  logic [IDX_W-1:0]   base_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RAW_W-1:0]   s0_raw;
  logic [IDX_W-1:0]   s0_idx;

  logic               s1_valid_q;
  logic               s2_valid_q;
  logic [COLOR_W-1:0] rd_q;
  logic [COLOR_W-1:0] s2_data_q;
  logic [COLOR_W-1:0] pal_mem [PAL_DEPTH];

  // ScreenStop blocks new words in the very cycle it is high.
  assign word_wrfull     = wrfull_q | ScreenStop;
  assign word_accept     = bus.WORD_wrreq & ~word_wrfull;
  assign adv             = ~bus.FF_wrfull;
  assign bus.WORD_wrfull = word_wrfull;
  assign bus.FF_wrreq    = s2_valid_q & ~bus.FF_wrfull & ~ScreenStop;
  assign bus.FF_data     = s2_data_q;

  // S0: pick the LSB pixel of the held word and form its palette index.
  always_comb begin
    s0_raw     = '0;
    word_shift = word_q;
    case (mode_q)
      2'd0: begin
        s0_raw     = RAW_W'(word_q[0]);
        word_shift = word_q >> 1;
      end
      2'd1: begin
        s0_raw     = RAW_W'(word_q[1:0]);
        word_shift = word_q >> 2;
      end
      2'd2: begin
        s0_raw     = RAW_W'(word_q[3:0]);
        word_shift = word_q >> 4;
      end
      default: begin
        s0_raw     = word_q[RAW_W-1:0];
        word_shift = word_q >> RAW_W;
      end
    endcase
    s0_idx = (mode_q == 2'd3) ? IDX_W'(s0_raw)
                              : IDX_W'(base_q + IDX_W'(s0_raw));
  end

  // Word-holder control: next state and per-cycle load/advance strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    s0_adv  = 1'b0;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (word_accept) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (adv) begin
          s0_adv = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (ScreenStop) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      s0_adv  = 1'b0;
    end
  end

  // State register; WORD_wrfull follows "not idle" one cycle later.
  always_ff @(posedge MemClk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_INIT;
      wrfull_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wrfull_q <= (state_d != ST_IDLE);
    end
  end

  // Held word, pixel count and S1/S2 valid/data registers.
  always_ff @(posedge MemClk or negedge Reset) begin
    if (!Reset) begin
      word_q     <= '0;
      mode_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (ScreenStop) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (load) begin
        word_q <= bus.WORD_data;
        mode_q <= Mode;
        base_q <= PalBase;
        cnt_q  <= CNT_W'(WORD_W >> Mode);
      end else if (s0_adv) begin
        word_q <= word_shift;
        cnt_q  <= cnt_q - CNT_W'(1);
      end
      if (adv) begin
        s1_valid_q <= s0_adv;
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= rd_q;
        end
      end
    end
  end

  // Palette RAM: writes always honoured; read-during-write returns old data.
  always_ff @(posedge MemClk) begin
    if (PAL_wren) begin
      pal_mem[PAL_wraddress] <= PAL_data;
    end
    if (adv) begin
      rd_q <= pal_mem[s0_idx];
    end
  end

endmodule
